cle_sdrd_deserializer: RTL and testbench

//  Downstream consumer of the CLE06 bus-snoop sequencer's serial data output (SDRD).

---
 rtl/cle_pkg.sv | 6 +
 rtl/cle_bus_sync.sv | 40 ++++
 rtl/cle_sdrd_deserializer.sv | 99 +++++++++
 tb/tb_cle_sdrd_deserializer.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/cle_pkg.sv
// cle_pkg: decode window and deserializer state type shared by the CLE06 SDRD consumer.
package cle_pkg;
    localparam logic CLE_WIN_BA13 = 1'b0;
    localparam logic CLE_WIN_BA12 = 1'b1;
    typedef enum logic [1:0] {IDLE, SHIFT, ABORT} cle_deser_state_e;
endpackage

// File: rtl/cle_bus_sync.sv
// cle_bus_sync: synchronises the async bus-snoop inputs and turns each qualified read into a one-clk sample event.
module cle_bus_sync
    import cle_pkg::*;
#(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sser_n_i,
    input  logic ba13_i,
    input  logic ba12_i,
    input  logic br_w_i,
    input  logic sdrd_i,
    output logic sample_evt_o,
    output logic sdrd_s_o
);
    logic [STAGES-1:0] sser_q, ba13_q, ba12_q, brw_q, sdrd_q;
    logic qual, qual_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sser_q <= '0;
            ba13_q <= '0;
            ba12_q <= '0;
            brw_q  <= '0;
            sdrd_q <= '0;
            qual_q <= 1'b0;
        end else begin
            sser_q <= {sser_q[STAGES-2:0], sser_n_i};
            ba13_q <= {ba13_q[STAGES-2:0], ba13_i};
            ba12_q <= {ba12_q[STAGES-2:0], ba12_i};
            brw_q  <= {brw_q[STAGES-2:0], br_w_i};
            sdrd_q <= {sdrd_q[STAGES-2:0], sdrd_i};
            qual_q <= qual;
        end
    end
    assign qual = ~sser_q[STAGES-1] & (ba13_q[STAGES-1] == CLE_WIN_BA13)
                & (ba12_q[STAGES-1] == CLE_WIN_BA12) & brw_q[STAGES-1];
    assign sample_evt_o = qual & ~qual_q;
    assign sdrd_s_o     = sdrd_q[STAGES-1];
endmodule

// File: rtl/cle_sdrd_deserializer.sv
// cle_sdrd_deserializer: assembles one SDRD bit per qualified CPU read into words,
// with a valid/ready holding register, sticky overrun and inter-bit timeout abort.
module cle_sdrd_deserializer
    import cle_pkg::*;
#(
    parameter int WORD_W      = 8,
    parameter bit MSB_FIRST   = 1'b1,
    parameter int TIMEOUT     = 1023,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sser_n,
    input  logic [9:0]        ba,
    input  logic              br_w,
    input  logic              sdrd,
    output logic [WORD_W-1:0] word_data,
    output logic              word_valid,
    input  logic              word_ready,
    output logic [4:0]        bit_count,
    output logic              overrun,
    output logic              timeout,
    input  logic              clr_flags
);
    localparam logic [15:0] TMO = 16'(TIMEOUT);
    cle_deser_state_e  state_q;
    logic [WORD_W-1:0] shift_q, shift_d, data_q;
    logic [4:0]        cnt_q;
    logic [15:0]       tmo_q;
    logic              valid_q, ovr_q, pulse_q, evt, sd, last, done;
    logic              unused_ba;
    assign unused_ba = ^ba[7:0];
    cle_bus_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk          (clk),
        .rst_n        (rst_n),
        .sser_n_i     (sser_n),
        .ba13_i       (ba[9]),
        .ba12_i       (ba[8]),
        .br_w_i       (br_w),
        .sdrd_i       (sdrd),
        .sample_evt_o (evt),
        .sdrd_s_o     (sd)
    );
    // shift_q is zero outside a word, so the first bit needs no special case
    assign shift_d = MSB_FIRST ? {shift_q[WORD_W-2:0], sd} : {sd, shift_q[WORD_W-1:1]};
    assign last    = cnt_q == 5'(WORD_W - 1);
    assign done    = evt && (state_q == SHIFT) && last;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shift_q <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
            tmo_q   <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            pulse_q <= 1'b0;
            case (state_q)
                SHIFT: begin
                    if (evt) begin
                        tmo_q   <= '0;
                        shift_q <= last ? '0 : shift_d;
                        cnt_q   <= last ? 5'd0 : cnt_q + 5'd1;
                        state_q <= last ? IDLE : SHIFT;
                    end else if (tmo_q == TMO - 16'd1) begin
                        tmo_q   <= TMO;
                        shift_q <= '0;
                        cnt_q   <= '0;
                        pulse_q <= 1'b1;
                        state_q <= ABORT;
                    end else begin
                        tmo_q <= tmo_q + 16'd1;
                    end
                end
                default: begin
                    tmo_q   <= '0;
                    shift_q <= evt ? shift_d : '0;
                    cnt_q   <= evt ? 5'd1 : 5'd0;
                    state_q <= evt ? SHIFT : IDLE;
                end
            endcase
            // a full holding register only takes the new word if it is drained in the same clk
            if (done && (!valid_q || word_ready)) begin
                data_q  <= shift_d;
                valid_q <= 1'b1;
            end else if (valid_q && word_ready) begin
                valid_q <= 1'b0;
            end
            ovr_q <= (done && valid_q && !word_ready) || (ovr_q && !clr_flags);
        end
    end
    assign word_data  = data_q;
    assign word_valid = valid_q;
    assign bit_count  = cnt_q;
    assign overrun    = ovr_q;
    assign timeout    = pulse_q;
endmodule

// File: tb/tb_cle_sdrd_deserializer.sv
// tb_cle_sdrd_deserializer: table vectors, hand-timed corner sequences and a random bus stream
// checked against a bit-queue model of the deserializer.
module tb_cle_sdrd_deserializer;
    logic       clk = 0, rst_n = 0, sser_n = 1, br_w = 0, sdrd = 0, word_ready = 0, clr_flags = 0;
    logic [9:0] ba = '0;
    logic [7:0] word_data;
    logic       word_valid, overrun, timeout;
    logic [4:0] bit_count;
    int         total = 0, bad = 0, tp = 0;

    typedef struct {
        logic       s;
        logic [1:0] hi;
        logic       bw;
        logic       d;
        int         hold;
        logic [4:0] bc;
        logic       v;
    } vec_t;
    vec_t tbl[12];

    cle_sdrd_deserializer #(.WORD_W(8), .MSB_FIRST(1'b1), .TIMEOUT(1023), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .sser_n(sser_n), .ba(ba), .br_w(br_w), .sdrd(sdrd),
        .word_data(word_data), .word_valid(word_valid), .word_ready(word_ready),
        .bit_count(bit_count), .overrun(overrun), .timeout(timeout), .clr_flags(clr_flags)
    );

    always #5 clk = ~clk;
    always @(negedge clk) if (timeout) tp++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic set_bus(input logic s, input logic [1:0] hi, input logic bw, input logic d);
        sser_n = s;
        ba     = {hi, 8'($urandom)};
        br_w   = bw;
        sdrd   = d;
    endtask

    task automatic bus(input logic s, input logic [1:0] hi, input logic bw, input logic d, input int hold);
        @(negedge clk);
        set_bus(s, hi, bw, d);
        repeat (hold) @(negedge clk);
        set_bus(1'b1, 2'b00, 1'b0, 1'b0);
        repeat (5) @(negedge clk);
    endtask

    task automatic rd(input logic d);
        bus(1'b0, 2'b01, 1'b1, d, 4);
    endtask

    task automatic send(input logic [7:0] w, input int n);
        for (int i = 0; i < n; i++) rd(w[7-i]);
    endtask

    task automatic take(input logic [7:0] exp, input string name);
        int n = 0;
        while (!word_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({name, " valid"}, word_valid, 1);
        chk({name, " data"}, word_data, exp);
        word_ready = 1;
        @(negedge clk);
        word_ready = 0;
        chk({name, " drop"}, word_valid, 0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int         t0;
        logic       q[$];
        logic       s, bw, d;
        logic [1:0] hi;
        logic [7:0] exp;
        tbl[0]  = '{1'b0, 2'b01, 1'b1, 1'b1, 4,  5'd1, 1'b0};
        tbl[1]  = '{1'b0, 2'b00, 1'b1, 1'b0, 4,  5'd1, 1'b0};
        tbl[2]  = '{1'b0, 2'b01, 1'b1, 1'b0, 20, 5'd2, 1'b0};
        tbl[3]  = '{1'b0, 2'b01, 1'b0, 1'b1, 4,  5'd2, 1'b0};
        tbl[4]  = '{1'b0, 2'b01, 1'b1, 1'b1, 4,  5'd3, 1'b0};
        tbl[5]  = '{1'b0, 2'b11, 1'b1, 1'b0, 4,  5'd3, 1'b0};
        tbl[6]  = '{1'b0, 2'b01, 1'b1, 1'b0, 4,  5'd4, 1'b0};
        tbl[7]  = '{1'b1, 2'b01, 1'b1, 1'b1, 4,  5'd4, 1'b0};
        tbl[8]  = '{1'b0, 2'b01, 1'b1, 1'b0, 4,  5'd5, 1'b0};
        tbl[9]  = '{1'b0, 2'b01, 1'b1, 1'b1, 1,  5'd6, 1'b0};
        tbl[10] = '{1'b0, 2'b01, 1'b1, 1'b0, 4,  5'd7, 1'b0};
        tbl[11] = '{1'b0, 2'b01, 1'b1, 1'b1, 4,  5'd0, 1'b1};

        repeat (3) @(negedge clk);
        chk("rst valid", word_valid, 0);
        chk("rst data", word_data, 0);
        chk("rst bc", bit_count, 0);
        chk("rst ovr", overrun, 0);
        chk("rst tmo", timeout, 0);
        rst_n = 1;

        send(8'hA5, 7);
        chk("t1 bc7", bit_count, 7);
        @(negedge clk);
        set_bus(1'b0, 2'b01, 1'b1, 1'b1);
        @(negedge clk);
        chk("t1 lat1", word_valid, 0);
        @(negedge clk);
        chk("t1 lat2", word_valid, 0);
        @(negedge clk);
        chk("t1 lat3", word_valid, 1);
        chk("t1 data", word_data, 8'hA5);
        chk("t1 bc0", bit_count, 0);
        set_bus(1'b1, 2'b00, 1'b0, 1'b0);
        repeat (5) @(negedge clk);
        take(8'hA5, "t1");

        foreach (tbl[i]) begin
            bus(tbl[i].s, tbl[i].hi, tbl[i].bw, tbl[i].d, tbl[i].hold);
            chk($sformatf("t2[%0d] bc", i), bit_count, tbl[i].bc);
            chk($sformatf("t2[%0d] valid", i), word_valid, tbl[i].v);
        end
        take(8'hA5, "t2");

        for (int i = 0; i < 3; i++) rd(1'b1);
        chk("t3 bc3", bit_count, 3);
        t0 = tp;
        repeat (990) @(negedge clk);
        chk("t3 early", tp - t0, 0);
        repeat (60) @(negedge clk);
        chk("t3 pulse", tp - t0, 1);
        chk("t3 bc", bit_count, 0);
        chk("t3 valid", word_valid, 0);
        send(8'hFF, 8);
        take(8'hFF, "t3");

        send(8'h3C, 8);
        chk("t4 first", word_data, 8'h3C);
        send(8'hC3, 8);
        chk("t4 hold", word_data, 8'h3C);
        chk("t4 valid", word_valid, 1);
        chk("t4 ovr", overrun, 1);
        clr_flags = 1;
        @(negedge clk);
        clr_flags = 0;
        chk("t4 clr", overrun, 0);
        take(8'h3C, "t4");

        send(8'h3C, 8);
        send(8'hC3, 7);
        @(negedge clk);
        set_bus(1'b0, 2'b01, 1'b1, 1'b1);
        @(negedge clk);
        chk("t5 v1", word_valid, 1);
        @(negedge clk);
        chk("t5 old", word_data, 8'h3C);
        word_ready = 1;
        @(negedge clk);
        word_ready = 0;
        chk("t5 no gap", word_valid, 1);
        chk("t5 new", word_data, 8'hC3);
        set_bus(1'b1, 2'b00, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        chk("t5 ovr", overrun, 0);
        take(8'hC3, "t5");

        send(8'h5A, 8);
        send(8'h00, 8);
        send(8'hF0, 5);
        chk("t6 pre ovr", overrun, 1);
        chk("t6 pre bc", bit_count, 5);
        @(negedge clk);
        #2 rst_n = 0;
        #1;
        chk("t6 valid", word_valid, 0);
        chk("t6 data", word_data, 0);
        chk("t6 bc", bit_count, 0);
        chk("t6 ovr", overrun, 0);
        chk("t6 tmo", timeout, 0);
        @(negedge clk);
        rst_n = 1;
        send(8'h69, 8);
        take(8'h69, "t6");
        chk("t6 ovr after", overrun, 0);

        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(9) < 6) begin
                s = 0; hi = 2'b01; bw = 1;
            end else begin
                s = 1'($urandom); hi = 2'($urandom); bw = 1'($urandom);
            end
            d = 1'($urandom);
            bus(s, hi, bw, d, $urandom_range(6, 1));
            if (!s && hi == 2'b01 && bw) q.push_back(d);
            if (q.size() == 8) begin
                exp = 0;
                foreach (q[k]) exp = exp | (8'(q[k]) << (7 - k));
                take(exp, $sformatf("rnd%0d", n));
                q.delete();
            end else begin
                chk($sformatf("rnd%0d bc", n), bit_count, 5'(q.size()));
            end
        end
        chk("rnd ovr", overrun, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
